// File: rtl/uart_top.sv
// Memory-mapped 8N1 UART: DATA register at 0x8, STATUS at 0xC.
// Transmitter and receiver run independently from clk_bus.
module uart_top #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [3:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [3:0]  ADDR_DATA   = 4'h8;
  localparam logic [3:0]  ADDR_STATUS = 4'hC;
  localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST   = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n;
  logic        tx_ready;
  logic        tx_accept;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_done;
  logic        rx_valid, rx_valid_n;
  logic [7:0]  rx_byte, rx_byte_n;
  logic        data_read;

  // Only the low byte of a write is meaningful.
  logic [23:0] unused_write_bits;
  assign unused_write_bits = bus_data_i[31:8];

  assign tx_ready  = (tx_state == TX_IDLE);
  assign tx_accept = bus_write && (bus_address == ADDR_DATA) && tx_ready;
  assign data_read = bus_read && (bus_address == ADDR_DATA);

  always_comb begin
    bus_data_o = 32'h0;
    if (bus_read) begin
      case (bus_address)
        ADDR_DATA:   bus_data_o = {24'h0, rx_byte};
        ADDR_STATUS: bus_data_o = {30'h0, rx_valid, tx_ready};
        default:     bus_data_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  // txd_n is the line level for the bit being entered, so txd stays a clean flop output.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (tx_accept) begin
          tx_state_n = TX_START;
          tx_shift_n = bus_data_i[7:0];
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
          txd_n      = 1'b1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
      rx_byte  <= rx_byte_n;
    end
  end

  // START waits half a bit, after which every full-bit count lands on a bit centre.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_done    = rx_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // A completing byte takes priority over a simultaneous DATA read.
  always_comb begin
    rx_valid_n = rx_valid;
    rx_byte_n  = rx_byte;
    if (data_read) rx_valid_n = 1'b0;
    if (rx_done) begin
      rx_valid_n = 1'b1;
      rx_byte_n  = rx_shift;
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top with CLKS_PER_BIT=16: register map, loopback,
// TX framing, RX glitch/framing/overrun handling and reset behaviour.
module tb_uart_top;

  localparam int CPB = 16;

  logic        clk_bus;
  logic        rst;
  logic [3:0]  bus_address;
  logic [31:0] bus_data_i;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_o;
  logic        txd;
  logic        rxd;
  logic        rxd_drv;
  logic        loopback;

  int check_count;
  int error_count;

  uart_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk_bus     (clk_bus),
    .rst         (rst),
    .bus_address (bus_address),
    .bus_data_i  (bus_data_i),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_data_o  (bus_data_o),
    .txd         (txd),
    .rxd         (rxd)
  );

  assign rxd = loopback ? txd : rxd_drv;

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic bus_write_op(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk_bus);
    bus_address = addr;
    bus_data_i  = data;
    bus_write   = 1'b1;
    @(negedge clk_bus);
    bus_write   = 1'b0;
  endtask

  task automatic bus_read_op(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk_bus);
    bus_address = addr;
    bus_read    = 1'b1;
    #1 data = bus_data_o;
    @(negedge clk_bus);
    bus_read    = 1'b0;
  endtask

  task automatic wait_status(input int bit_pos, input logic want, input int limit, input string tag);
    logic [31:0] st;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      bus_read_op(4'hC, st);
      if (st[bit_pos] === want) seen = 1'b1;
    end
    checkOutput(tag, {31'h0, seen}, 32'h1);
  endtask

  // Drives one serial frame onto rxd, then leaves the line idle for two bit times.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (CPB) @(negedge clk_bus);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = value[i];
      repeat (CPB) @(negedge clk_bus);
    end
    rxd_drv = stop_bit;
    repeat (CPB) @(negedge clk_bus);
    rxd_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk_bus);
  endtask

  logic [31:0] rd;
  logic [7:0]  lb_bytes [8];
  logic        samples [0:191];
  logic        all_eq;
  logic        idle_ok;
  logic        seen_new;
  logic [9:0]  tx_pattern;

  initial begin
    check_count = 0;
    error_count = 0;
    rst         = 1'b1;
    bus_address = 4'h0;
    bus_data_i  = 32'h0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    rxd_drv     = 1'b1;
    loopback    = 1'b0;
    lb_bytes    = '{8'hAA, 8'h00, 8'h55, 8'hFF, 8'h01, 8'h80, 8'h92, 8'hA7};
    tx_pattern  = 10'b1010101010;

    repeat (3) @(negedge clk_bus);
    checkOutput("txd_in_reset", {31'h0, txd}, 32'h1);
    rst = 1'b0;
    bus_read_op(4'hC, rd);
    checkOutput("status_after_reset", rd, 32'h1);
    bus_read_op(4'h8, rd);
    checkOutput("data_after_reset", rd, 32'h0);
    bus_read_op(4'h4, rd);
    checkOutput("unmapped_read", rd, 32'h0);
    @(negedge clk_bus);
    bus_address = 4'hC;
    bus_read    = 1'b0;
    #1 checkOutput("no_read_strobe", bus_data_o, 32'h0);

    bus_write_op(4'hC, 32'h12);
    bus_write_op(4'h0, 32'h34);
    bus_read_op(4'hC, rd);
    checkOutput("write_status_ignored", rd, 32'h1);
    checkOutput("txd_idle", {31'h0, txd}, 32'h1);

    $display("[TB] loopback phase");
    loopback = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_status(0, 1'b1, 200, $sformatf("lb%0d_tx_ready", n));
      bus_write_op(4'h8, {24'hFFFFFF, lb_bytes[n]});
      wait_status(1, 1'b1, 200, $sformatf("lb%0d_rx_valid", n));
      bus_read_op(4'h8, rd);
      checkOutput($sformatf("lb%0d_data", n), rd, {24'h0, lb_bytes[n]});
      bus_read_op(4'hC, rd);
      checkOutput($sformatf("lb%0d_valid_cleared", n), {31'h0, rd[1]}, 32'h0);
    end
    wait_status(0, 1'b1, 200, "lb_final_tx_ready");
    loopback = 1'b0;

    $display("[TB] tx framing with ignored second write");
    @(negedge clk_bus);
    bus_address = 4'h8;
    bus_data_i  = 32'h55;
    bus_write   = 1'b1;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk_bus);
      samples[k] = txd;
      if (k == 0) bus_data_i = 32'h33;
      if (k == 1) bus_write = 1'b0;
    end
    for (int b = 0; b < 10; b++) begin
      all_eq = 1'b1;
      for (int j = 0; j < CPB; j++)
        if (samples[b * CPB + j] !== samples[b * CPB]) all_eq = 1'b0;
      checkOutput($sformatf("tx_bit%0d", b), {30'h0, all_eq, samples[b * CPB]}, {30'h0, 1'b1, tx_pattern[b]});
    end
    idle_ok = 1'b1;
    for (int k = 160; k < 192; k++)
      if (samples[k] !== 1'b1) idle_ok = 1'b0;
    checkOutput("tx_no_second_frame", {31'h0, idle_ok}, 32'h1);
    bus_read_op(4'hC, rd);
    checkOutput("status_after_frame", rd, 32'h1);

    $display("[TB] rx glitch rejection");
    @(negedge clk_bus);
    rxd_drv = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk_bus);
    rxd_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk_bus);
    bus_read_op(4'hC, rd);
    checkOutput("glitch_no_byte", rd, 32'h1);

    $display("[TB] rx overrun and framing error");
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hC5, 1'b1);
    bus_read_op(4'hC, rd);
    checkOutput("overrun_valid", rd, 32'h3);
    bus_read_op(4'h8, rd);
    checkOutput("overrun_data", rd, 32'hC5);
    applyStimulus(8'h7E, 1'b0);
    bus_read_op(4'hC, rd);
    checkOutput("frame_err_valid_low", rd, 32'h1);
    bus_read_op(4'h8, rd);
    checkOutput("frame_err_data_kept", rd, 32'hC5);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b0);
    bus_read_op(4'hC, rd);
    checkOutput("frame_err_valid_high", rd, 32'h3);
    bus_read_op(4'h8, rd);
    checkOutput("frame_err_data_first", rd, 32'h11);

    $display("[TB] set wins over simultaneous data read");
    seen_new = 1'b0;
    fork
      applyStimulus(8'h5A, 1'b1);
      begin
        bus_address = 4'h8;
        bus_read    = 1'b1;
        for (int i = 0; i < 12 * CPB && !seen_new; i++) begin
          @(negedge clk_bus);
          if (bus_data_o === 32'h5A) seen_new = 1'b1;
        end
        bus_address = 4'hC;
        #1 checkOutput("set_wins_valid", {31'h0, bus_data_o[1]}, 32'h1);
        bus_read = 1'b0;
      end
    join
    checkOutput("set_wins_seen", {31'h0, seen_new}, 32'h1);
    bus_read_op(4'h8, rd);
    checkOutput("set_wins_data", rd, 32'h5A);

    $display("[TB] reset during tx frame");
    applyStimulus(8'h77, 1'b1);
    wait_status(0, 1'b1, 200, "pre_reset_tx_ready");
    bus_write_op(4'h8, 32'h0F);
    repeat (5 * CPB + 8) @(negedge clk_bus);
    checkOutput("txd_bit4", {31'h0, txd}, 32'h0);
    rst = 1'b1;
    @(negedge clk_bus);
    checkOutput("txd_after_rst", {31'h0, txd}, 32'h1);
    rst = 1'b0;
    bus_address = 4'hC;
    bus_read    = 1'b1;
    #1 checkOutput("status_after_rst", bus_data_o, 32'h1);
    bus_address = 4'h8;
    #1 checkOutput("data_after_rst", bus_data_o, 32'h0);
    bus_read = 1'b0;

    @(negedge clk_bus);
    rst = 1'b1;
    @(negedge clk_bus);
    rst         = 1'b0;
    bus_address = 4'h8;
    bus_data_i  = 32'h3C;
    bus_write   = 1'b1;
    @(negedge clk_bus);
    bus_write   = 1'b0;
    bus_address = 4'hC;
    bus_read    = 1'b1;
    #1 checkOutput("first_write_accepted", bus_data_o, 32'h0);
    checkOutput("first_write_start_bit", {31'h0, txd}, 32'h0);
    bus_read = 1'b0;
    wait_status(0, 1'b1, 200, "final_tx_ready");

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk_bus.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_bus cycles per serial bit (115200 baud at 50 MHz); legal range is 8 to 65535.
REQ-003 clk_bus  input  1  sole clock for the bus interface and the serial logic.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 bus_address  input  4  register select: 0x8 = DATA, 0xC = STATUS.
REQ-006 bus_data_i  input  32  write data; only bits [7:0] are used.
REQ-007 bus_read  input  1  read strobe.
REQ-008 bus_write  input  1  write strobe, one cycle per access.
REQ-009 bus_data_o  output  32  read data.
REQ-010 txd  output  1  serial transmit line, idle high.
REQ-011 rxd  input  1  serial receive line, asynchronous, idle high.

Function
REQ-012 bus_data_o SHALL be combinational from bus_address and bus_read, so it is valid in the same cycle the address is presented.
REQ-013 When bus_read=0, or bus_address is not 0x8 or 0xC, bus_data_o SHALL be 0.
REQ-014 Reading STATUS SHALL return bit0=tx_ready, bit1=rx_valid and bits[31:2]=0.
REQ-015 Reading DATA SHALL return {24'b0, rx_byte}.
REQ-016 Reading DATA SHALL clear rx_valid at the end of that cycle.
REQ-017 tx_ready SHALL be 1 when the transmitter is idle; it goes 0 in the cycle after an accepted write and returns to 1 after the stop bit completes.
REQ-018 A write to DATA with tx_ready=1 SHALL latch bus_data_i[7:0] and start a frame; a write while tx_ready=0 SHALL be ignored.
REQ-019 Writes to STATUS and to unmapped addresses SHALL have no effect.
REQ-020 The TX frame SHALL be 8N1, LSB first: start bit 0, 8 data bits, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-021 The TX state machine SHALL have states IDLE, START, DATA(bit index 0-7) and STOP, with STOP returning to IDLE.
REQ-022 txd SHALL be driven from a register (glitch-free).
REQ-023 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-024 The RX state machine SHALL have states IDLE, START, DATA and STOP.
REQ-025 In IDLE, a synchronized falling edge SHALL enter START.
REQ-026 In START, the line SHALL be resampled at CLKS_PER_BIT/2; if it is 1 the receiver SHALL return to IDLE (glitch rejection), otherwise it enters DATA.
REQ-027 In DATA, the 8 bits SHALL be sampled at bit centres, LSB first.
REQ-028 In STOP, the line SHALL be sampled at the centre of the stop bit.
REQ-029 If the stop bit is 1, rx_byte SHALL be updated and rx_valid set; if it is 0 (framing error), the byte SHALL be discarded and rx_valid left unchanged.
REQ-030 After STOP the receiver SHALL return to IDLE and be able to accept a new start bit immediately.
REQ-031 Overrun: a new valid byte arriving while rx_valid=1 SHALL overwrite rx_byte, and rx_valid stays 1.
REQ-032 If a DATA read clears rx_valid in the same cycle a new byte completes, the set SHALL win: rx_valid=1 and the new byte is held.
REQ-033 TX and RX SHALL be fully independent; transmitting and receiving at the same time SHALL be supported.

Reset
REQ-034 While rst=1: txd=1, tx_ready=1, rx_valid=0, rx_byte=0x00, both state machines in IDLE, bit counters and synchronizer flops set to idle/1.
REQ-035 Reset asserted mid-frame SHALL abort the frame at the next clock edge; txd goes to 1 and no partial byte is delivered.
REQ-036 The first write SHALL be accepted in the first cycle after rst is released.

Verification
REQ-037 After reset, read STATUS -> 0x00000001; read DATA -> 0x00000000.
REQ-038 Loopback (rxd follows txd), with CLKS_PER_BIT=16: write bytes 0xAA, 0x00, 0x55, 0xFF, 0x01, 0x80, 0x92, 0xA7 in turn, each after polling STATUS bit0=1 -> after each frame STATUS bit1=1, DATA reads back the same byte, and STATUS bit1 then reads 0.
REQ-039 Write 0x55 and then, while tx_ready=0, write 0x33 -> only 0x55 is sent; txd shows exactly 10 bits of CLKS_PER_BIT cycles, pattern 0,1,0,1,0,1,0,1,0,1.
REQ-040 Low pulse on rxd shorter than CLKS_PER_BIT/2 cycles -> no byte received, rx_valid stays 0.
REQ-041 Send two bytes into rxd without reading DATA -> DATA returns the second byte; a frame with stop bit 0 -> rx_valid unchanged.
REQ-042 Assert rst during bit 4 of a TX frame -> txd=1 on the next clock and STATUS reads 0x1 once rst is released.
